dcdl_code_readback: RTL and testbench
=====================================

Name: dcdl_code_readback

Overview:
- Receive-side checker for the delay-line control bus: the 16-bit coarse and two 8-bit fine one-hot codes with their complements.
- Re-encodes the bus to the 10-bit binary delay code and checks that each one-hot code and its complement are well formed.
- Tracks code stability to raise a lock flag and keeps a saturating error count.
- Sits beside the delay line and taps the same T/Tb buses; its outputs feed test/observability logic and the top-level lock indicator.

Parameters:
- LOCK_CNT, 8: number of consecutive identical valid samples required to assert locked (legal range 2..255).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk_ext, input, 1: sole clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- sample_en, input, 1: qualifies the bus; sampled only when high.
- T, input, 16: coarse one-hot (code bits 9:6).
- Tb, input, 16: coarse complement.
- T_f1, input, 8: fine-1 one-hot (code bits 5:3).
- Tb_f1, input, 8: fine-1 complement.
- T_f2, input, 8: fine-2 one-hot (code bits 2:0).
- Tb_f2, input, 8: fine-2 complement.
- clr_err, input, 1: synchronous clear of err_cnt and code_err.
- code_out, output, 10: last good encoded code.
- code_valid, output, 1: one-cycle pulse when a valid sample completes.
- code_err, output, 1: sticky malformed-sample flag.
- code_change, output, 1: one-cycle pulse when a valid code differs from the previous good code.
- locked, output, 1: high while in LOCKED.
- err_cnt, output, ERR_W: saturating count of malformed samples.

Behaviour:
- Reset (async, rst_n low): all outputs 0, code_out=0, state=IDLE, stability count=0, pipeline regs cleared. Reset mid-sample discards that sample.
- Stage 1: when sample_en=1, register all six vectors.
  - Stage 2, next cycle: classify and encode.
  - Outputs update on the second rising edge after the sample_en edge (latency 2).
  - sample_en may be high every cycle; throughput is one sample per cycle.
- Classification:
  - IDLE pattern: all six vectors zero. This is the decoder reset state and is not an error.
  - VALID: every T-field has exactly one bit set AND every Tb-field equals the bitwise inverse of its T-field.
  - ERROR: anything else, including a partial-zero mix, multi-hot, zero-hot with nonzero Tb, or a complement mismatch.
- Encoding: code = {index(T), index(T_f1), index(T_f2)}; index is the position of the set bit (4, 3 and 3 bits).
- FSM states: IDLE, ACQUIRE, LOCKED. cnt is 8 bits.
  - IDLE: VALID -> ACQUIRE with cnt=1. IDLE pattern stays. ERROR stays IDLE.
  - ACQUIRE, VALID and same as code_out: cnt+1. When cnt+1 == LOCK_CNT -> LOCKED.
  - ACQUIRE, VALID and different: cnt=1 and pulse code_change.
  - ACQUIRE, ERROR: cnt=0, stay in ACQUIRE.
  - ACQUIRE, IDLE pattern: -> IDLE with cnt=0.
  - LOCKED, same VALID code: stay.
  - LOCKED, different VALID code: -> ACQUIRE with cnt=1 and pulse code_change.
  - LOCKED, ERROR: -> ACQUIRE with cnt=0.
  - LOCKED, IDLE pattern: -> IDLE.
  - locked is a registered decode of the state; it falls in the same cycle the FSM leaves LOCKED.
- Sample effects:
  - code_out loads only on VALID samples and holds through ERROR and IDLE samples.
  - code_valid pulses on every VALID sample.
  - The first VALID sample after IDLE does not pulse code_change.
- ERROR sample: code_err set (sticky); err_cnt increments and saturates at all-ones.
- clr_err:
  - clears code_err and err_cnt.
  - If it coincides with an ERROR sample, the result is err_cnt=1 and code_err=1.
  - clr_err does not affect the FSM or code_out.
- sample_en low: the pipeline holds and no pulses are produced; the FSM does not advance.

Decomposition:
- Shared package dcdl_pkg:
  - FSM state enum {IDLE, ACQUIRE, LOCKED}.
  - Field widths: COARSE_W=16, FINE_W=8, CODE_W=10.
  - Sample class enum {S_IDLE, S_VALID, S_ERR}.
- One sub-module, onehot_check_enc, parameterised by width N:
  - Inputs: t and tb.
  - Outputs: ok, zero and idx[$clog2(N)-1:0].
  - Instantiate it three times.

Test Plan:
- Reset then IDLE pattern for 10 samples -> state IDLE, locked=0, code_valid never pulses, err_cnt=0.
- Sample code 10'h29D for 8 consecutive cycles. Bus: T=16'h0400, Tb=16'hFBFF, T_f1=8'h08, Tb_f1=8'hF7, T_f2=8'h20, Tb_f2=8'hDF. Expect: code_out=10'h29D two cycles after the first sample, locked rises on the edge for the 8th sample plus latency, code_change never pulses.
- While locked, change to T_f2=8'h40, Tb_f2=8'hBF -> code_out=10'h29E, one code_change pulse, locked drops, then re-locks after 8 more samples.
- Inject T=16'h0401 (two-hot), then a Tb_f1 mismatch -> err_cnt=2, code_err=1, code_out still 10'h29E, locked=0. Follow with 8 valid samples to re-lock.
- Force 300 ERROR samples with clr_err pulsed on the 300th -> err_cnt saturates at 8'hFF and reads 1 after the coincident clear.
- Assert rst_n low mid-ACQUIRE with sample_en active -> all outputs 0 immediately (asynchronously); after release, state is IDLE.

Source files
------------

// File: rtl/dcdl_pkg.sv
// dcdl_pkg: shared widths, FSM states and sample classes for the delay-line code readback
package dcdl_pkg;
  localparam int COARSE_W = 16;
  localparam int FINE_W = 8;
  localparam int CODE_W = 10;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  typedef enum logic [1:0] {S_IDLE, S_VALID, S_ERR} sclass_t;
endpackage

// File: rtl/onehot_check_enc.sv
// onehot_check_enc: checks a one-hot field against its complement and encodes its index
module onehot_check_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0]         t,
  input  logic [N-1:0]         tb,
  output logic                 ok,
  output logic                 zero,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);
  assign zero = (t == '0) && (tb == '0);
  assign ok = $onehot(t) && (tb == ~t);
  // OR of set-bit positions; exact whenever the field is one-hot
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) idx = t[i] ? (idx | IW'(i)) : idx;
  end
endmodule

// File: rtl/dcdl_code_readback.sv
// dcdl_code_readback: re-encodes the delay-line T/Tb bus, checks it and tracks lock
module dcdl_code_readback
  import dcdl_pkg::*;
#(
  parameter int LOCK_CNT = 8,
  parameter int ERR_W = 8
) (
  input  logic                clk_ext,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic [COARSE_W-1:0] T,
  input  logic [COARSE_W-1:0] Tb,
  input  logic [FINE_W-1:0]   T_f1,
  input  logic [FINE_W-1:0]   Tb_f1,
  input  logic [FINE_W-1:0]   T_f2,
  input  logic [FINE_W-1:0]   Tb_f2,
  input  logic                clr_err,
  output logic [CODE_W-1:0]   code_out,
  output logic                code_valid,
  output logic                code_err,
  output logic                code_change,
  output logic                locked,
  output logic [ERR_W-1:0]    err_cnt
);
  logic [COARSE_W-1:0] t_q, tb_q;
  logic [FINE_W-1:0] f1_q, f1b_q, f2_q, f2b_q;
  logic s1_v, s2_v;
  logic c_ok, c_zero, f1_ok, f1_zero, f2_ok, f2_zero;
  logic [3:0] c_idx;
  logic [2:0] f1_idx, f2_idx;
  sclass_t cls_d, s2_cls;
  logic [CODE_W-1:0] s2_code;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic is_valid, is_err, is_idle, same, chg_d, valid_d, locked_d, err_hit;

  onehot_check_enc #(.N(COARSE_W)) u_coarse (.t(t_q), .tb(tb_q), .ok(c_ok), .zero(c_zero), .idx(c_idx));
  onehot_check_enc #(.N(FINE_W)) u_fine1 (.t(f1_q), .tb(f1b_q), .ok(f1_ok), .zero(f1_zero), .idx(f1_idx));
  onehot_check_enc #(.N(FINE_W)) u_fine2 (.t(f2_q), .tb(f2b_q), .ok(f2_ok), .zero(f2_zero), .idx(f2_idx));

  assign cls_d = (c_zero && f1_zero && f2_zero) ? S_IDLE : (c_ok && f1_ok && f2_ok) ? S_VALID : S_ERR;
  assign is_valid = s2_cls == S_VALID;
  assign is_err = s2_cls == S_ERR;
  assign is_idle = s2_cls == S_IDLE;
  assign same = s2_code == code_out;

  // stage 1: capture the raw bus when qualified
  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      {t_q, tb_q, f1_q, f1b_q, f2_q, f2b_q} <= '0;
    end else begin
      s1_v <= sample_en;
      if (sample_en) {t_q, tb_q, f1_q, f1b_q, f2_q, f2b_q} <= {T, Tb, T_f1, Tb_f1, T_f2, Tb_f2};
    end
  end

  // stage 2: register classification and encoded code
  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      s2_v <= 1'b0;
      s2_cls <= S_IDLE;
      s2_code <= '0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_cls <= cls_d;
        s2_code <= {c_idx, f1_idx, f2_idx};
      end
    end
  end

  // FSM state and stability counter
  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end

  // next state: only a completed sample advances the FSM
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (s2_v) begin
      case (state_q)
        IDLE: if (is_valid) begin
          state_d = ACQUIRE;
          cnt_d = 8'd1;
        end
        ACQUIRE: if (is_valid && same) begin
          cnt_d = cnt_q + 8'd1;
          state_d = (cnt_d == 8'(LOCK_CNT)) ? LOCKED : ACQUIRE;
        end else if (is_valid) cnt_d = 8'd1;
        else if (is_err) cnt_d = 8'd0;
        else begin
          state_d = IDLE;
          cnt_d = 8'd0;
        end
        LOCKED: if (is_valid && !same) begin
          state_d = ACQUIRE;
          cnt_d = 8'd1;
        end else if (is_err) begin
          state_d = ACQUIRE;
          cnt_d = 8'd0;
        end else if (is_idle) begin
          state_d = IDLE;
          cnt_d = 8'd0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // output decode; locked follows the next state so it drops with the exit from LOCKED
  always_comb begin
    valid_d = s2_v && is_valid;
    chg_d = valid_d && !same && (state_q != IDLE);
    locked_d = state_d == LOCKED;
    err_hit = s2_v && is_err;
  end

  // registered outputs, sticky error flag and saturating error count
  always_ff @(posedge clk_ext or negedge rst_n) begin
    if (!rst_n) begin
      code_out <= '0;
      code_valid <= 1'b0;
      code_change <= 1'b0;
      locked <= 1'b0;
      code_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      code_out <= valid_d ? s2_code : code_out;
      code_valid <= valid_d;
      code_change <= chg_d;
      locked <= locked_d;
      if (clr_err) begin
        code_err <= err_hit;
        err_cnt <= ERR_W'(err_hit);
      end else if (err_hit) begin
        code_err <= 1'b1;
        err_cnt <= (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dcdl_code_readback.sv
// tb_dcdl_code_readback: directed self-checking bench for dcdl_code_readback
module tb_dcdl_code_readback;
  logic clk_ext = 1'b0;
  logic rst_n, sample_en, clr_err;
  logic [15:0] T, Tb;
  logic [7:0] T_f1, Tb_f1, T_f2, Tb_f2;
  logic [9:0] code_out;
  logic code_valid, code_err, code_change, locked;
  logic [7:0] err_cnt;
  int errors = 0;
  int checks = 0;

  dcdl_code_readback #(.LOCK_CNT(8), .ERR_W(8)) dut (
    .clk_ext(clk_ext), .rst_n(rst_n), .sample_en(sample_en),
    .T(T), .Tb(Tb), .T_f1(T_f1), .Tb_f1(Tb_f1), .T_f2(T_f2), .Tb_f2(Tb_f2),
    .clr_err(clr_err), .code_out(code_out), .code_valid(code_valid),
    .code_err(code_err), .code_change(code_change), .locked(locked), .err_cnt(err_cnt)
  );

  always #5 clk_ext = ~clk_ext;

  task set_code(input logic [9:0] c);
    T = 16'd1 << c[9:6];
    Tb = ~T;
    T_f1 = 8'd1 << c[5:3];
    Tb_f1 = ~T_f1;
    T_f2 = 8'd1 << c[2:0];
    Tb_f2 = ~T_f2;
  endtask

  task set_idle;
    {T, Tb, T_f1, Tb_f1, T_f2, Tb_f2} = '0;
  endtask

  task tick;
    @(posedge clk_ext);
    #1;
  endtask

  task test_reset;
    rst_n = 1'b0;
    sample_en = 1'b0;
    clr_err = 1'b0;
    set_idle();
    #3;
    checks++;
    if (code_out !== 10'h0) begin errors++; $display("FAIL reset_code_out got=%h exp=000", code_out); end
    checks++;
    if ({code_valid, code_err, code_change, locked} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {code_valid, code_err, code_change, locked}); end
    checks++;
    if (err_cnt !== 8'h0) begin errors++; $display("FAIL reset_err_cnt got=%h exp=00", err_cnt); end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task test_idle;
    sample_en = 1'b1;
    set_idle();
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if ({code_valid, code_change, locked, code_err} !== 4'b0) begin errors++; $display("FAIL idle_flags[%0d] got=%b exp=0000", i, {code_valid, code_change, locked, code_err}); end
      checks++;
      if (err_cnt !== 8'h0) begin errors++; $display("FAIL idle_err_cnt[%0d] got=%h exp=00", i, err_cnt); end
    end
  endtask

  task test_lock;
    set_code(10'h29D);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (code_out !== (i >= 2 ? 10'h29D : 10'h000)) begin errors++; $display("FAIL lock_code_out[%0d] got=%h exp=%h", i, code_out, (i >= 2 ? 10'h29D : 10'h000)); end
      checks++;
      if ({code_valid, code_change, locked} !== {i >= 2, 1'b0, i >= 9}) begin errors++; $display("FAIL lock_flags[%0d] got=%b exp=%b", i, {code_valid, code_change, locked}, {i >= 2, 1'b0, i >= 9}); end
    end
  endtask

  task test_change;
    set_code(10'h29E);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (code_out !== (i >= 2 ? 10'h29E : 10'h29D)) begin errors++; $display("FAIL change_code_out[%0d] got=%h exp=%h", i, code_out, (i >= 2 ? 10'h29E : 10'h29D)); end
      checks++;
      if ({code_change, locked} !== {i == 2, (i < 2) || (i >= 9)}) begin errors++; $display("FAIL change_flags[%0d] got=%b exp=%b", i, {code_change, locked}, {i == 2, (i < 2) || (i >= 9)}); end
    end
  endtask

  task test_errors;
    for (int i = 0; i < 12; i++) begin
      set_code(10'h29E);
      if (i == 0) begin T = 16'h0401; Tb = ~T; end
      if (i == 1) Tb_f1 = Tb_f1 ^ 8'h01;
      tick();
      checks++;
      if (err_cnt !== (i < 2 ? 8'd0 : i == 2 ? 8'd1 : 8'd2)) begin errors++; $display("FAIL err_cnt[%0d] got=%h exp=%h", i, err_cnt, (i < 2 ? 8'd0 : i == 2 ? 8'd1 : 8'd2)); end
      checks++;
      if ({code_err, code_valid, code_change, locked} !== {i >= 2, (i < 2) || (i >= 4), 1'b0, (i < 2) || (i >= 11)}) begin errors++; $display("FAIL err_flags[%0d] got=%b exp=%b", i, {code_err, code_valid, code_change, locked}, {i >= 2, (i < 2) || (i >= 4), 1'b0, (i < 2) || (i >= 11)}); end
      checks++;
      if (code_out !== 10'h29E) begin errors++; $display("FAIL err_code_out[%0d] got=%h exp=29e", i, code_out); end
    end
  endtask

  task test_saturate;
    set_code(10'h29E);
    T = 16'h0401;
    Tb = ~T;
    for (int i = 0; i < 302; i++) begin
      sample_en = i < 300;
      clr_err = i == 301;
      tick();
      if (i == 300) begin
        checks++;
        if (err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_err_cnt got=%h exp=ff", err_cnt); end
      end
      if (i == 301) begin
        checks++;
        if ({code_err, err_cnt} !== {1'b1, 8'h01}) begin errors++; $display("FAIL sat_clear_coincident got=%b/%h exp=1/01", code_err, err_cnt); end
      end
    end
    clr_err = 1'b0;
    tick();
    checks++;
    if (err_cnt !== 8'h01) begin errors++; $display("FAIL sat_hold got=%h exp=01", err_cnt); end
    checks++;
    if ({code_out, locked} !== {10'h29E, 1'b0}) begin errors++; $display("FAIL sat_code_lock got=%h/%b exp=29e/0", code_out, locked); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if ({code_err, err_cnt} !== {1'b0, 8'h00}) begin errors++; $display("FAIL clr_only got=%b/%h exp=0/00", code_err, err_cnt); end
  endtask

  task test_async_reset;
    set_code(10'h29D);
    sample_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({code_out, code_valid} !== {10'h29D, 1'b1}) begin errors++; $display("FAIL pre_reset got=%h/%b exp=29d/1", code_out, code_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (code_out !== 10'h0) begin errors++; $display("FAIL async_code_out got=%h exp=000", code_out); end
    checks++;
    if ({code_valid, code_err, code_change, locked, err_cnt} !== 12'h0) begin errors++; $display("FAIL async_flags got=%h exp=000", {code_valid, code_err, code_change, locked, err_cnt}); end
    #2;
    rst_n = 1'b1;
    sample_en = 1'b0;
    set_idle();
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({code_out, code_valid, code_change, locked} !== 13'h0) begin errors++; $display("FAIL post_reset_hold got=%h exp=0000", {code_out, code_valid, code_change, locked}); end
    set_code(10'h29D);
    sample_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({code_out, code_valid, code_change, locked} !== {10'h29D, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL post_reset_first got=%h/%b%b%b exp=29d/100", code_out, code_valid, code_change, locked); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_lock();
    test_change();
    test_errors();
    test_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
